// File: rtl/mms_pkg.sv
// Shared MMU types for the ITLB controller: FSM states, tag record and VPN width.
// Provides fallback values for ITLB_ENTRY_SIZE and MXLEN when the build does not set them.
`ifndef ITLB_ENTRY_SIZE
`define ITLB_ENTRY_SIZE 31
`endif
`ifndef MXLEN
`define MXLEN 64
`endif

package mms_pkg;
  localparam int ITLB_VPN_W = 27;

  typedef enum logic [1:0] {
    IDLE,
    PTW_REQ,
    PTW_WAIT,
    REFILL
  } itlb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [ITLB_VPN_W-1:0] vpn;
  } itlb_tag_t;
endpackage

// File: rtl/itlb_victim_sel.sv
// ITLB replacement choice: the lowest-index invalid entry, otherwise a round-robin pointer
// that advances only when a refill lands in a completely full array.
module itlb_victim_sel
  import mms_pkg::*;
#(
  parameter int ENTRY_NUM = `ITLB_ENTRY_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ENTRY_NUM-1:0] valid_i,
  input  logic                 commit_i,
  output logic [ENTRY_NUM-1:0] victim_o
);
  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [ENTRY_NUM-1:0] first_inv;
  logic                 all_valid;

  always_comb begin
    first_inv = '0;
    // Scan downward so the last hit, the lowest index, wins.
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        first_inv    = '0;
        first_inv[i] = 1'b1;
      end
    end
    all_valid = &valid_i;
    victim_o  = all_valid ? (ENTRY_NUM'(1) << rr_ptr) : first_inv;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (commit_i && all_valid) begin
      rr_ptr <= (rr_ptr == PTR_W'(ENTRY_NUM - 1)) ? '0 : rr_ptr + PTR_W'(1);
    end
  end
endmodule

// File: rtl/itlb_ctrl.sv
// ITLB lookup/refill controller: tag match, PTW request/response handling and victim refill.
// Optional ITLB_PERF_CNT_EN adds saturating hit/miss counters; otherwise the counter ports read 0.
module itlb_ctrl
  import mms_pkg::*;
#(
  parameter int ENTRY_NUM = `ITLB_ENTRY_SIZE,
  parameter int VPN_W     = ITLB_VPN_W,
  parameter int PTE_W     = `MXLEN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lookup_valid_i,
  input  logic [VPN_W-1:0]     lookup_vpn_i,
  output logic                 lookup_ready_o,
  output logic                 hit_o,
  output logic                 miss_o,
  output logic [ENTRY_NUM-1:0] rd_en_o,
  output logic [ENTRY_NUM-1:0] wr_en_o,
  output logic [PTE_W-1:0]     pte_wr_o,
  output logic                 ptw_req_valid_o,
  input  logic                 ptw_req_ready_i,
  output logic [VPN_W-1:0]     ptw_req_vpn_o,
  input  logic                 ptw_resp_valid_i,
  input  logic [PTE_W-1:0]     ptw_resp_pte_i,
  input  logic                 ptw_resp_fault_i,
  output logic                 refill_done_o,
  output logic                 fault_o,
  input  logic                 flush_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);
  itlb_state_e          state_q, state_d;
  logic                 kill_q, kill_d;
  itlb_tag_t            tag_q [ENTRY_NUM];
  logic [VPN_W-1:0]     walk_vpn_q;
  logic [PTE_W-1:0]     pte_q;
  logic [ENTRY_NUM-1:0] valid_vec;
  logic [ENTRY_NUM-1:0] match_vec;
  logic [ENTRY_NUM-1:0] victim;
  logic                 latch_vpn;
  logic                 latch_pte;
  logic                 refill_we;

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      valid_vec[i] = tag_q[i].valid;
      match_vec[i] = tag_q[i].valid && (tag_q[i].vpn == lookup_vpn_i);
    end
  end

  itlb_victim_sel #(
    .ENTRY_NUM(ENTRY_NUM)
  ) u_victim_sel (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_vec),
    .commit_i(refill_we),
    .victim_o(victim)
  );

  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    lookup_ready_o  = 1'b0;
    hit_o           = 1'b0;
    miss_o          = 1'b0;
    rd_en_o         = '0;
    wr_en_o         = '0;
    pte_wr_o        = '0;
    ptw_req_valid_o = 1'b0;
    ptw_req_vpn_o   = '0;
    refill_done_o   = 1'b0;
    fault_o         = 1'b0;
    latch_vpn       = 1'b0;
    latch_pte       = 1'b0;
    refill_we       = 1'b0;
    case (state_q)
      IDLE: begin
        lookup_ready_o = !flush_i;
        kill_d         = 1'b0;
        if (lookup_valid_i && !flush_i) begin
          if (|match_vec) begin
            hit_o   = 1'b1;
            rd_en_o = match_vec;
          end else begin
            miss_o    = 1'b1;
            latch_vpn = 1'b1;
            state_d   = PTW_REQ;
          end
        end
      end
      PTW_REQ: begin
        // The request is never withdrawn; a flush only marks the walk as stale.
        ptw_req_valid_o = 1'b1;
        ptw_req_vpn_o   = walk_vpn_q;
        if (flush_i) kill_d = 1'b1;
        if (ptw_req_ready_i) state_d = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (flush_i) kill_d = 1'b1;
        if (ptw_resp_valid_i) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (kill_q || flush_i) begin
            state_d = IDLE;
          end else if (ptw_resp_fault_i) begin
            fault_o = 1'b1;
          end else begin
            latch_pte = 1'b1;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        state_d = IDLE;
        if (!flush_i) begin
          refill_we     = 1'b1;
          wr_en_o       = victim;
          pte_wr_o      = pte_q;
          refill_done_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Only the valid bits are reset; tag VPNs are don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < ENTRY_NUM; i++) tag_q[i].valid <= 1'b0;
    end else if (refill_we) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (victim[i]) begin
          tag_q[i].valid <= 1'b1;
          tag_q[i].vpn   <= walk_vpn_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (latch_vpn) walk_vpn_q <= lookup_vpn_i;
    if (latch_pte) pte_q      <= ptw_resp_pte_i;
  end

`ifdef ITLB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_o)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (miss_o) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: doc/itlb_ctrl.md
Name: itlb_ctrl

Overview:
- Lookup/refill controller directly upstream of the ITLB entry array.
- Holds a VPN tag + valid array and matches fetch VPNs against it.
- Drives one-hot rd_en on a hit and one-hot wr_en plus the PTE on a refill.
- On a miss, requests a walk from the PTW, then writes the returned PTE into a victim entry.

Parameters:
- ENTRY_NUM, `ITLB_ENTRY_SIZE (31), number of entries; must match the entry array.
- VPN_W, 27, Sv39 VPN width.
- PTE_W, `MXLEN (64), PTE width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lookup_valid_i  in  1  fetch translation request
- lookup_vpn_i  in  VPN_W  VPN to translate
- lookup_ready_o  out  1  controller in IDLE and able to accept a lookup
- hit_o  out  1  lookup hit this cycle
- miss_o  out  1  one-cycle pulse when a lookup misses
- rd_en_o  out  ENTRY_NUM  one-hot read select to the entry array
- wr_en_o  out  ENTRY_NUM  one-hot write select to the entry array
- pte_wr_o  out  PTE_W  PTE to write
- ptw_req_valid_o  out  1  walk request valid
- ptw_req_ready_i  in  1  PTW accepts the request
- ptw_req_vpn_o  out  VPN_W  VPN to walk
- ptw_resp_valid_i  in  1  walk response valid
- ptw_resp_pte_i  in  PTE_W  leaf PTE
- ptw_resp_fault_i  in  1  walk fault
- refill_done_o  out  1  one-cycle pulse when an entry is written
- fault_o  out  1  one-cycle pulse when the walk faults
- flush_i  in  1  sfence.vma: invalidate all entries

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - all valid bits 0; state IDLE; round-robin pointer 0; kill flag 0.
  - all outputs 0, except lookup_ready_o = 1 once in IDLE.
- Lookup in IDLE:
  - Match is combinational, zero latency.
  - Hit: lookup_valid_i high and some valid entry has tag == lookup_vpn_i.
    - hit_o = 1 and rd_en_o is one-hot at that entry in the same cycle.
  - Miss (no matching entry):
    - miss_o pulses.
    - VPN is latched into the walk-VPN register.
    - Next state PTW_REQ.
- PTW_REQ:
  - ptw_req_valid_o = 1 and ptw_req_vpn_o = latched VPN, held stable until ptw_req_ready_i.
  - On handshake, next state PTW_WAIT.
  - lookup_ready_o = 0 in every non-IDLE state.
- PTW_WAIT: on ptw_resp_valid_i:
  - If kill is set: discard the response, clear kill, go to IDLE.
  - Else if ptw_resp_fault_i: fault_o pulses, nothing is written, go to IDLE.
  - Else: register the PTE, go to REFILL.
- REFILL (one cycle):
  - wr_en_o one-hot at the victim; pte_wr_o = registered PTE.
  - Tag is written and valid set for that entry.
  - refill_done_o pulses; next state IDLE.
  - rd_en_o = 0 during this cycle.
- Victim selection:
  - Lowest-index invalid entry, if any.
  - Otherwise the round-robin pointer, which then increments and wraps ENTRY_NUM-1 -> 0.
  - The pointer only advances on refills into a full array.
- Flush:
  - All valid bits clear on the next edge, in any state.
  - In IDLE: flush_i takes priority over a same-cycle lookup; hit_o = 0, no miss, lookup_ready_o = 0 that cycle.
  - In PTW_REQ or PTW_WAIT: kill is set. The request handshake still completes (valid is never withdrawn), and the response is dropped.
  - In REFILL: the write is suppressed (wr_en_o = 0), refill_done_o = 0, go to IDLE.
- rd_en_o and wr_en_o are never both non-zero in the same cycle.
- Reset mid-walk: FSM returns to IDLE and any later PTW response is ignored. The PTW is reset by the same rst_i.

Optional Feature:
- Macro: ITLB_PERF_CNT_EN.
- Defined:
  - Adds 32-bit saturating counters hit_cnt_o and miss_cnt_o.
  - They count hit_o and miss_o pulses, saturate at 32'hFFFF_FFFF, and are cleared by rst_i and flush_i.
- Undefined:
  - Ports still exist, tied to 0; no counter flops.

Decomposition:
- Shared mms_pkg:
  - itlb_state_e {IDLE, PTW_REQ, PTW_WAIT, REFILL}.
  - ITLB_VPN_W constant.
  - itlb_tag_t struct {logic valid; logic [VPN_W-1:0] vpn}.
- Sub-module itlb_victim_sel:
  - First-invalid priority encoder plus round-robin pointer.
  - Outputs a one-hot victim.

Test Plan:
- Cold miss: reset, lookup VPN 27'h00123.
  - miss_o pulses; ptw_req_vpn_o = 27'h00123.
  - Response PTE 64'h0000_0000_2000_00CF -> wr_en_o = 31'h1, refill_done_o pulses.
  - Repeat lookup -> hit_o = 1, rd_en_o = 31'h1 in the same cycle.
- Fill and replace: refill 31 distinct VPNs -> wr_en_o walks bit 0..30. The 32nd miss writes entry 0, the 33rd writes entry 1 (round-robin).
- Fault: PTW responds with ptw_resp_fault_i = 1 -> fault_o pulses, wr_en_o stays 0, the next lookup of the same VPN misses again.
- Flush during walk: assert flush_i in PTW_WAIT, then response arrives -> no write, FSM returns to IDLE, all prior entries miss.
- Backpressure: hold ptw_req_ready_i = 0 for 5 cycles -> ptw_req_valid_o and ptw_req_vpn_o stay stable, lookup_ready_o = 0 throughout.
- Flush + lookup in the same IDLE cycle on a resident VPN -> hit_o = 0, miss_o = 0; the next lookup misses.
